// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store types, funct3 codes and access-size helpers.
// Used by lsu_bus_bridge and lsu_load_align.
package rv32i_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3[1:0]: 00 byte, 01 half, anything else is a full word
  function automatic logic is_byte(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      is_byte(f3): be = 4'(4'b0001 << off);
      is_half(f3): be = off[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] r;
    r = d;
    unique case (1'b1)
      is_byte(f3): r = {4{d[7:0]}};
      is_half(f3): r = {2{d[15:0]}};
      default:     r = d;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      is_byte(f3): m = 1'b0;
      is_half(f3): m = off[0];
      default:     m = off != 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a bus read word and
// sign- or zero-extends it for write-back.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = 8'(rdata >> {off, 3'b000});
  assign h = 16'(rdata >> {off[1], 4'b0000});

  always_comb begin
    data = rdata;
    unique case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the RV32I core and a req/gnt/rvalid bus.
// Optional misalign trap: define LSU_MISALIGN_TRAP_EN.
module lsu_bus_bridge
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_load,
  input  logic        core_store,
  input  logic [2:0]  core_funct3,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        ld_done,
  output logic        stall,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  lsu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [29:0]      addr_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic             we_q;
  logic             err_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [31:0]      ld_data;
  logic             go;
  logic             tmo;
  logic             mis;
  logic             busy;

  assign go   = core_load | core_store;
  assign tmo  = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign busy = (state == S_REQ) | (state == S_WAIT_RSP);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = misaligned(core_funct3, core_addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_load_align u_align (
    .rdata  (bus_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (go) state_n = mis ? S_DONE : S_REQ;
      S_REQ:
        if (tmo)          state_n = S_DONE;
        else if (bus_gnt) state_n = we_q ? S_DONE : S_WAIT_RSP;
      S_WAIT_RSP:
        if (bus_rvalid | tmo) state_n = S_DONE;
      S_DONE:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && go) begin
        addr_q  <= core_addr[31:2];
        off_q   <= core_addr[1:0];
        f3_q    <= core_funct3;
        we_q    <= ~core_load;
        be_q    <= lane_be(core_funct3, core_addr[1:0]);
        wdata_q <= lane_data(core_funct3, core_wdata);
        cnt     <= '0;
        rdata_q <= '0;
        err_q   <= mis;
      end
      if (busy) cnt <= cnt + CNT_W'(1);
      // Completion in the final counted cycle beats the timeout
      if (state == S_WAIT_RSP && bus_rvalid) rdata_q <= ld_data;
      else if (busy && tmo)                  err_q   <= 1'b1;
    end
  end

  assign bus_req    = (state == S_REQ) & ~tmo;
  assign bus_we     = we_q;
  assign bus_addr   = {addr_q, 2'b00};
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign ld_done    = state == S_DONE;
  assign bus_err    = ld_done & err_q;
  assign core_rdata = rdata_q;
  assign stall      = ((state == S_IDLE) & go) | busy;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Randomized self-checking bench for lsu_bus_bridge against a
// transaction-level reference model (TIMEOUT_CYCLES=8).
module tb_lsu_bus_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_load = 1'b0;
  logic        core_store = 1'b0;
  logic [2:0]  core_funct3 = '0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        ld_done, stall, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_cmp = 0;
  int n_err = 0;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(T), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .core_load   (core_load),
    .core_store  (core_store),
    .core_funct3 (core_funct3),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .ld_done     (ld_done),
    .stall       (stall),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int acc_w(input bit ld, input logic [2:0] f3);
    case (f3)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd4:    return ld ? 1 : 4;
      3'd5:    return ld ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                           input logic [1:0] off,
                                           input logic [2:0] f3);
    int unsigned b, h, o;
    o = off;
    b = (rd >> (8 * o)) % 256;
    h = (rd >> (16 * (o / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // One transaction: gnt after g REQ cycles, rvalid r cycles after gnt
  task automatic txn(input bit ld, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int g, input int r,
                     input bit noise);
    logic [3:0]  ebe;
    logic [31:0] ewd, erd;
    bit mis, fin, err;
    int k, w, o;
    w = acc_w(ld, f3);
    o = a[1:0];
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (w == 2 && o % 2 == 1) || (w == 4 && o != 0);
`endif
    if (w == 1) begin
      ebe = 4'(1 << o);
      ewd = {4{wd[7:0]}};
    end else if (w == 2) begin
      ebe = (o >= 2) ? 4'b1100 : 4'b0011;
      ewd = {2{wd[15:0]}};
    end else begin
      ebe = 4'b1111;
      ewd = wd;
    end
    erd = ref_load(rd, a[1:0], f3);
    @(negedge clk);
    core_load   = ld;
    core_store  = ld ? 1'($urandom) : 1'b1;
    core_funct3 = f3;
    core_addr   = a;
    core_wdata  = wd;
    bus_gnt     = 1'b0;
    bus_rvalid  = 1'b0;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_req", bus_req, 0);
    fin = mis;
    err = mis;
    k = 0;
    while (!fin) begin
      @(negedge clk);
      core_addr   = $urandom;
      core_wdata  = $urandom;
      core_funct3 = 3'($urandom);
      bus_gnt     = (k == g);
      bus_rvalid  = (ld && k == g + r) || (noise && k == g);
      bus_rdata   = (ld && k == g + r) ? rd : $urandom;
      #1;
      chk("req", bus_req, (k <= g) && (k != T - 1));
      chk("stall", stall, 1);
      chk("done_early", ld_done, 0);
      chk("addr", bus_addr, {a[31:2], 2'b00});
      chk("we", bus_we, !ld);
      if (!ld) begin
        chk("be", bus_be, ebe);
        chk("wdata", bus_wdata, ewd);
      end
      if (!ld && k == g && k < T - 1) fin = 1;
      else if (ld && g < T - 1 && k == g + r) fin = 1;
      else if (k == T - 1) begin
        fin = 1;
        err = 1;
      end
      k++;
    end
    @(negedge clk);
    core_load  = 1'b0;
    core_store = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = noise;
    bus_rdata  = $urandom;
    #1;
    chk("ld_done", ld_done, 1);
    chk("done_stall", stall, 0);
    chk("bus_err", bus_err, err);
    chk("done_req", bus_req, 0);
    if (ld || err) chk("rdata", core_rdata, err ? 32'h0 : erd);
    if (!mis) chk("done_addr", bus_addr, {a[31:2], 2'b00});
    @(negedge clk);
    bus_rvalid = 1'($urandom);
    #1;
    chk("idle_done", ld_done, 0);
    chk("idle_err", bus_err, 0);
    chk("idle_stall0", stall, 0);
    bus_rvalid = 1'b0;
  endtask

  initial begin
    int sf [6];
    sf = '{0, 1, 2, 3, 6, 7};
    #3;
    chk("rst_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", core_rdata, 0);
    @(negedge clk);
    reset = 1'b0;

    txn(0, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    txn(0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 0);
    txn(1, 3'b000, 32'h102, 0, 32'h0080FF00, 0, 1, 0);
    txn(1, 3'b100, 32'h102, 0, 32'h0080FF00, 0, 1, 1);
    txn(1, 3'b001, 32'h102, 0, 32'h80000000, 5, 1, 0);
    txn(1, 3'b010, 32'h200, 0, 32'h12345678, 0, 100, 0);
    txn(0, 3'b001, 32'h302, 32'h0000BEEF, 0, T - 1, 0, 0);
    txn(1, 3'b010, 32'h404, 0, 32'hCAFEF00D, 2, T - 3, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn(1, 3'b010, 32'h101, 0, 32'h11111111, 0, 1, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      bit ld;
      int g, r;
      logic [2:0] f3;
      ld = 1'($urandom);
      f3 = ld ? 3'($urandom) : 3'(sf[$urandom_range(0, 5)]);
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 9)
                                      : $urandom_range(0, 3);
      r = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(1, 3);
      txn(ld, f3, $urandom, $urandom, $urandom, g, r, 1'($urandom));
    end

    @(negedge clk);
    core_load   = 1'b1;
    core_funct3 = 3'b010;
    core_addr   = 32'h500;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    chk("pre_rst_stall", stall, 1);
    core_load = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_req", bus_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_addr", bus_addr, 0);
    chk("arst_we", bus_we, 0);
    chk("arst_be", bus_be, 0);
    chk("arst_done", ld_done, 0);
    @(negedge clk);
    reset = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h55AA55AA;
    #1;
    chk("post_rst_done", ld_done, 0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    chk("post_rst_done2", ld_done, 0);
    chk("post_rst_rdata", core_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
